dmem_banked_rw: RTL and testbench
=================================

Name: dmem_banked_rw

Overview:
- Parametrised successor to the single-port data memory, used by the datapath's load/store stage.
- Adds a valid/ready request port, per-byte write enables, a configurable read pipeline (1 or 2 cycles), and a post-reset clearing sweep.
- Memory contents are all-zero after reset, so loads from unwritten addresses are deterministic.

Parameters:
- DATA_W, 32: data word width in bits; must be a multiple of 8.
- DEPTH, 65536: number of words; must be a power of two, at least 4.
- ADDR_W, 32: width of the incoming word address.
- RD_LAT, 1: read latency in cycles; legal values are 1 and 2; any other value is a compile-time error.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous, active-low reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: block can accept a request this cycle.
- req_we, input, 1: 1 = write, 0 = read.
- req_be, input, DATA_W/8: byte-lane write enables; ignored on reads.
- req_addr, input, ADDR_W: word address; index = req_addr[IDX_W-1:0], where IDX_W = log2(DEPTH).
- req_wdata, input, DATA_W: write data.
- rsp_valid, output, 1: read data valid (single-cycle pulse per read).
- rsp_rdata, output, DATA_W: read data.
- init_done, output, 1: clearing sweep finished.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, state=INIT, sweep counter=0, read pipeline flushed.
- State machine:
  - INIT: writes 0 to word[cnt] each cycle and increments cnt. After the write to DEPTH-1, go to RUN and set init_done=1. The sweep takes exactly DEPTH cycles after rst_n deasserts.
  - RUN: req_ready=1 every cycle; no further state changes until reset.
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. In INIT, req_valid is ignored and no state changes. No response backpressure; the consumer must take rsp_rdata while rsp_valid=1.
- Write:
  - Byte lane k of word[index] is updated on the accept edge iff req_be[k]=1; other lanes are unchanged.
  - be=0 is a no-op.
  - Writes produce no response.
- Read with RD_LAT=1: accept at edge N gives rsp_valid=1 with data in the cycle after edge N. rsp_valid drops after one cycle unless another read is accepted.
- Read with RD_LAT=2: the array output is registered a second time; data appears in the cycle after edge N+1.
- Throughput: one request per cycle, back-to-back, for any mix of reads and writes.
- Write then read of the same address on consecutive accept edges: the read returns the new data. No forwarding logic is needed because the array write completes on the accept edge.
- rsp_rdata holds its last value when rsp_valid=0.
- Address: bits above IDX_W are ignored (aliasing) unless the optional feature is enabled.
- Reset mid-operation: any in-flight read is dropped (rsp_valid forced to 0) and the block re-enters INIT. Array contents are cleared again by the sweep.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- When defined:
  - Adds output rsp_err (1 bit, reset 0).
  - An accepted request with req_addr >= DEPTH is an out-of-range request.
  - Out-of-range write: suppressed; rsp_err pulses 1 in the cycle after the accept edge.
  - Out-of-range read: produces rsp_valid=1 with rsp_rdata=0 and rsp_err=1, at the normal RD_LAT timing.
- When not defined: no rsp_err port; high address bits alias as described above.

Decomposition:
- Package dmem_pkg:
  - state enum {INIT, RUN};
  - function clog2 for IDX_W;
  - constant BE_W = DATA_W/8;
  - RD_LAT legality check.
- Sub-module dmem_array: the byte-enabled storage array with one synchronous read/write port and an optional output register selected by RD_LAT.
- The top level holds the FSM, sweep counter, handshake, valid pipeline and bounds check.

Test Plan (bench overrides DEPTH=16):
- Release rst_n -> req_ready=0 for exactly 16 cycles, then init_done=1 and req_ready=1; reading addresses 0..15 returns 0x00000000 at each.
- Write addr 3, data 0xDEADBEEF, be=4'b1111; read addr 3 on the next cycle -> rsp_valid one cycle later (RD_LAT=1), rsp_rdata=0xDEADBEEF.
- Write addr 5, data 0x11223344, be=4'b1111; then write addr 5, data 0xAABBCCDD, be=4'b0101; read addr 5 -> rsp_rdata=0x11BB33DD.
- RD_LAT=2: back-to-back reads of addr 1,2,3 (preloaded 0xA,0xB,0xC) -> rsp_valid high for 3 consecutive cycles starting 2 cycles after the first accept, data 0xA,0xB,0xC in order.
- Assert rst_n=0 while a read is in flight -> rsp_valid=0 immediately; after release, INIT repeats and addr 3 reads 0.
- With DMEM_BOUNDS_CHECK_EN: write addr 20 with 0x55 -> rsp_err pulse and no write; read addr 20 -> rsp_valid=1, rsp_rdata=0, rsp_err=1; read addr 4 -> unchanged contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and elaboration helpers for the banked data memory.
package dmem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int be_width(input int data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic bit rd_lat_legal(input int rd_lat);
        return (rd_lat == 1) || (rd_lat == 2);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled single-port storage with a registered read; RD_LAT=2 adds an output register.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 65536,
    parameter int RD_LAT = 1,
    parameter int IDX_W  = clog2(DEPTH),
    parameter int BE_W   = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_zero,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wr_be[k]) begin
                    mem[idx][k*BYTE_W +: BYTE_W] <= wr_data[k*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data <= '0;
                end else if (rd_en) begin
                    rd_data <= rd_zero ? '0 : mem[idx];
                end
            end
        end else begin : g_lat2
            logic [DATA_W-1:0] ram_q_reg;
            logic              s1_vld_reg;
            logic              s1_zero_reg;

            // Unreset capture register keeps the array read path mappable onto block RAM.
            always_ff @(posedge clk) begin
                if (rd_en) begin
                    ram_q_reg <= mem[idx];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_vld_reg  <= 1'b0;
                    s1_zero_reg <= 1'b0;
                    rd_data     <= '0;
                end else begin
                    s1_vld_reg  <= rd_en;
                    s1_zero_reg <= rd_zero;
                    if (s1_vld_reg) begin
                        rd_data <= s1_zero_reg ? '0 : ram_q_reg;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/dmem_banked_rw.sv
// Data memory top: post-reset clearing sweep, request handshake and read-valid pipeline.
// Defining DMEM_BOUNDS_CHECK_EN adds rsp_err and suppresses out-of-range accesses.
module dmem_banked_rw
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 65536,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
`ifdef DMEM_BOUNDS_CHECK_EN
    output logic                rsp_err,
`endif
    output logic                init_done
);

    localparam int IDX_W = clog2(DEPTH);
    localparam int BE_W  = be_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    generate
        if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
            $error("dmem_banked_rw: RD_LAT must be 1 or 2");
        end
        if ((DATA_W % BYTE_W) != 0) begin : g_bad_data_w
            $error("dmem_banked_rw: DATA_W must be a multiple of 8");
        end
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("dmem_banked_rw: DEPTH must be a power of two, at least 4");
        end
    endgenerate

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  cnt_reg, cnt_next;
    logic              accept, rd_accept, wr_accept, addr_oor;
    logic              arr_we;
    logic [BE_W-1:0]   arr_be;
    logic [IDX_W-1:0]  arr_idx;
    logic [DATA_W-1:0] arr_wdata;
    logic [RD_LAT-1:0] vld_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= INIT;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_ready  = 1'b0;
        init_done  = 1'b0;
        case (state_reg)
            INIT: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == LAST_IDX) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_next = INIT;
        endcase
    end

    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;
    assign wr_accept = accept && req_we;

`ifdef DMEM_BOUNDS_CHECK_EN
    assign addr_oor = (64'(req_addr) >= 64'(DEPTH));
`else
    // High address bits alias onto the low index bits.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr;
    assign addr_oor       = 1'b0;
`endif

    // The sweep owns the array port until RUN, so INIT needs no request gating here.
    always_comb begin
        arr_we    = 1'b1;
        arr_be    = '1;
        arr_idx   = cnt_reg;
        arr_wdata = '0;
        if (state_reg == RUN) begin
            arr_we    = wr_accept && !addr_oor;
            arr_be    = req_be;
            arr_idx   = req_addr[IDX_W-1:0];
            arr_wdata = req_wdata;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT),
        .IDX_W  (IDX_W),
        .BE_W   (BE_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (arr_we),
        .wr_be   (arr_be),
        .idx     (arr_idx),
        .wr_data (arr_wdata),
        .rd_en   (rd_accept),
        .rd_zero (addr_oor),
        .rd_data (rsp_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
        end else begin
            vld_reg[0] <= rd_accept;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_reg[i] <= vld_reg[i-1];
            end
        end
    end

    assign rsp_valid = vld_reg[RD_LAT-1];

`ifdef DMEM_BOUNDS_CHECK_EN
    logic [RD_LAT-1:0] rerr_reg;
    logic              werr_reg;

    // Write errors report one cycle after accept; read errors ride along with their data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rerr_reg <= '0;
            werr_reg <= 1'b0;
        end else begin
            rerr_reg[0] <= rd_accept && addr_oor;
            for (int i = 1; i < RD_LAT; i++) begin
                rerr_reg[i] <= rerr_reg[i-1];
            end
            werr_reg <= wr_accept && addr_oor;
        end
    end

    assign rsp_err = rerr_reg[RD_LAT-1] | werr_reg;
`endif

endmodule

// File: tb/tb_dmem_banked_rw.sv
// Scoreboard bench for dmem_banked_rw: RD_LAT=1 and RD_LAT=2 instances share one request stream.
module tb_dmem_banked_rw;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 32;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef struct {
        int          due;
        bit          is_rd;
        logic [31:0] data;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [3:0]  req_be = 4'h0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        r1_ready, r1_valid, r1_done, r1_err;
    logic [31:0] r1_rdata;
    logic        r2_ready, r2_valid, r2_done, r2_err;
    logic [31:0] r2_rdata;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_txn = 0;
    exp_t        sb_q [2][$];
    logic [31:0] last_d [2];
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_banked_rw #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r1_ready),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(r1_valid), .rsp_rdata(r1_rdata),
`ifdef DMEM_BOUNDS_CHECK_EN
        .rsp_err(r1_err),
`endif
        .init_done(r1_done)
    );

    dmem_banked_rw #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r2_ready),
        .req_we(req_we), .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(r2_valid), .rsp_rdata(r2_rdata),
`ifdef DMEM_BOUNDS_CHECK_EN
        .rsp_err(r2_err),
`endif
        .init_done(r2_done)
    );

`ifndef DMEM_BOUNDS_CHECK_EN
    assign r1_err = 1'b0;
    assign r2_err = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        sb_q[0].delete();
        sb_q[1].delete();
        last_d[0] = '0;
        last_d[1] = '0;
    endtask

    // Monitor: collect whatever is due this cycle and compare against the port.
    task automatic check_port(input int p, input logic v, input logic e, input logic [31:0] d);
        bit          xv;
        bit          xe;
        logic [31:0] xd;
        xv = 1'b0;
        xe = 1'b0;
        xd = last_d[p];
        for (int i = sb_q[p].size() - 1; i >= 0; i--) begin
            if (sb_q[p][i].due == cyc) begin
                if (sb_q[p][i].is_rd) begin
                    xv = 1'b1;
                    xd = sb_q[p][i].data;
                end
                xe = xe | sb_q[p][i].err;
                sb_q[p].delete(i);
            end
        end
        n_cmp++;
        if (v !== xv || e !== xe || d !== xd) begin
            n_fail++;
            $display("FAIL rsp_lat%0d cyc=%0d: got valid=%0b err=%0b data=%h, expected valid=%0b err=%0b data=%h",
                     p + 1, cyc, v, e, d, xv, xe, xd);
        end
        last_d[p] = xd;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check_port(0, r1_valid, r1_err, r1_rdata);
            check_port(1, r2_valid, r2_err, r2_rdata);
        end
    end

    // Issue one request at posedge+1; it is accepted on the next edge, after which cyc = cyc+1.
    task automatic issue(input bit we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        bit   oor;
        int   idx;
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        oor = BOUNDS && (addr >= 32'(DEPTH));
        idx = int'(addr % 32'(DEPTH));
        e.is_rd = !we;
        e.err   = oor;
        e.data  = '0;
        if (we) begin
            if (oor) begin
                e.due = cyc + 1;
                sb_q[0].push_back(e);
                sb_q[1].push_back(e);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) model[idx][8*k +: 8] = wdata[8*k +: 8];
                end
            end
        end else begin
            e.data = oor ? 32'h0 : model[idx];
            e.due  = cyc + 1;
            sb_q[0].push_back(e);
            e.due  = cyc + 2;
            sb_q[1].push_back(e);
        end
        n_txn++;
        $display("txn %0d cyc=%0d %s addr=%h be=%b wdata=%h%s", n_txn, cyc, we ? "WR" : "RD",
                 addr, be, wdata, oor ? " out-of-range" : "");
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Release reset and time the sweep; a write presented during the sweep must be ignored.
    task automatic release_and_wait_init();
        int n;
        n = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 4'hF;
        req_addr  = 32'd3;
        req_wdata = 32'hFFFF_FFFF;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (r1_ready) break;
        end
        req_valid = 1'b0;
        chk("init_cycles", 32'(n), 32'd16);
        chk("init_done_lat1", 32'(r1_done), 32'd1);
        chk("init_done_lat2", 32'(r2_done), 32'd1);
        chk("ready_lat2", 32'(r2_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_model();
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(r1_ready), 32'd0);
        chk("rst_valid", 32'({r1_valid, r2_valid}), 32'd0);
        chk("rst_rdata_lat1", r1_rdata, 32'h0);
        chk("rst_rdata_lat2", r2_rdata, 32'h0);
        chk("rst_done", 32'({r1_done, r2_done}), 32'd0);
        chk("rst_err", 32'({r1_err, r2_err}), 32'd0);

        release_and_wait_init();

        for (int a = 0; a < DEPTH; a++) issue(1'b0, 4'h0, 32'(a), 32'h0);
        idle(3);

        issue(1'b1, 4'hF, 32'd3, 32'hDEAD_BEEF);
        issue(1'b0, 4'h0, 32'd3, 32'h0);
        issue(1'b1, 4'hF, 32'd5, 32'h1122_3344);
        issue(1'b1, 4'b0101, 32'd5, 32'hAABB_CCDD);
        issue(1'b0, 4'h0, 32'd5, 32'h0);
        issue(1'b1, 4'hF, 32'd1, 32'hA);
        issue(1'b1, 4'hF, 32'd2, 32'hB);
        issue(1'b1, 4'hF, 32'd3, 32'hC);
        issue(1'b0, 4'h0, 32'd1, 32'h0);
        issue(1'b0, 4'h0, 32'd2, 32'h0);
        issue(1'b0, 4'h0, 32'd3, 32'h0);
        idle(2);
        issue(1'b1, 4'h0, 32'd3, 32'hFFFF_FFFF);
        issue(1'b0, 4'h0, 32'd3, 32'h0);
        issue(1'b1, 4'hF, 32'd4, 32'h0000_1234);
        issue(1'b1, 4'hF, 32'd20, 32'h0000_0055);
        issue(1'b0, 4'h0, 32'd20, 32'h0);
        issue(1'b0, 4'h0, 32'd4, 32'h0);
        issue(1'b0, 4'h0, 32'h8000_0007, 32'h0);
        idle(3);

        for (int t = 0; t < 400; t++) begin
            logic [31:0] addr;
            if ($urandom_range(0, 9) == 0) addr = $urandom();
            else addr = 32'($urandom_range(0, BOUNDS ? 31 : DEPTH - 1));
            issue(1'($urandom_range(0, 1)), 4'($urandom()), addr, $urandom());
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        // Reset with a read in flight: both pipelines must drop it at once.
        issue(1'b1, 4'hF, 32'd3, 32'h0BAD_F00D);
        issue(1'b0, 4'h0, 32'd3, 32'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid_lat1", 32'(r1_valid), 32'd0);
        chk("midrst_valid_lat2", 32'(r2_valid), 32'd0);
        chk("midrst_rdata_lat1", r1_rdata, 32'h0);
        chk("midrst_ready", 32'(r1_ready), 32'd0);
        clear_model();
        release_and_wait_init();
        issue(1'b0, 4'h0, 32'd3, 32'h0);
        issue(1'b0, 4'h0, 32'd15, 32'h0);
        idle(4);

        chk("sb_drained_lat1", 32'(sb_q[0].size()), 32'd0);
        chk("sb_drained_lat2", 32'(sb_q[1].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
